// File: rtl/char_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : char_traffic_gen
// Description : Packetised stimulus generator for switching-activity
//               characterisation of datapath blocks. It emits NUM_PKTS
//               packets of PAYLOAD flits, with GAP idle cycles after each
//               packet. Each flit is a 2N-bit pattern word split into two
//               N-bit operands.
// Ports       : clk, rst (async, active-high)
//               start      - one-cycle request to begin a run
//               mode[1:0]  - 0 thermometer, 1 xorshift, 2 counter, 3 toggle
//               out_ready  - consumer accepts current flit
//               out_valid  - current flit valid
//               operand_a  - pattern word [N-1:0]
//               operand_b  - pattern word [2N-1:N]
//               flit_last  - current flit is the last of its packet
//               busy, done - run in progress / run complete
//               pkt_count  - packets fully accepted in this run (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module char_traffic_gen #(
    parameter int          N        = 15,
    parameter int          PAYLOAD  = 20,
    parameter int          GAP      = 7,
    parameter int          NUM_PKTS = 10,
    parameter logic [31:0] SEED     = 32'h1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] operand_a,
    output logic [N-1:0] operand_b,
    output logic         flit_last,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pkt_count
);

    localparam int W  = 2 * N;
    localparam int FW = (PAYLOAD  > 1) ? $clog2(PAYLOAD)  : 1;
    localparam int PW = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int GW = (GAP      > 1) ? $clog2(GAP)      : 1;

    localparam logic [W-1:0] c_ONES = {W{1'b1}};
    localparam logic [5:0]   c_W6   = 6'(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    r_mode;
    logic [W-1:0]  r_word;
    logic [31:0]   r_x;
    logic [5:0]    r_m;
    logic          r_ph;
    logic [FW-1:0] r_flit_idx;
    logic [PW-1:0] r_pkt_idx;
    logic [GW-1:0] r_gap_cnt;
    logic [15:0]   r_pkt_count;
    logic          r_valid;
    logic          r_flit_last;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_state_nxt;
    logic          w_start_ok;
    logic          w_accept;
    logic          w_last_flit;
    logic          w_last_pkt;
    logic          w_gap_end;
    logic          w_load;
    logic          w_pkt_start;
    logic [1:0]    w_mode_sel;
    logic [W-1:0]  w_prev;
    logic [5:0]    w_m_use;
    logic          w_ph_use;
    logic [5:0]    w_m_nxt;
    logic          w_ph_nxt;
    logic [31:0]   w_x1;
    logic [31:0]   w_x2;
    logic [31:0]   w_x_nxt;
    logic [W-1:0]  w_word_nxt;
    logic [FW-1:0] w_flit_idx_nxt;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept    = (r_state == S_SEND) && out_ready;
    assign w_last_flit = (r_flit_idx == FW'(PAYLOAD - 1));
    assign w_last_pkt  = (r_pkt_idx == PW'(NUM_PKTS - 1));
    assign w_gap_end   = (r_state == S_GAP) && (r_gap_cnt == '0);

    // Next state and the "load a new flit" strobe. w_pkt_start marks loads
    // that begin a fresh packet, where the pattern restarts from zero.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pkt_start = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_SEND;
                    w_load      = 1'b1;
                    w_pkt_start = 1'b1;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    if (!w_last_flit) begin
                        w_load = 1'b1;
                    end else if (GAP > 0) begin
                        w_state_nxt = S_GAP;
                    end else if (w_last_pkt) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_pkt_start = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    if (w_last_pkt) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_SEND;
                        w_load      = 1'b1;
                        w_pkt_start = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The mode is taken straight from the port for the very first flit,
    // since the latched copy only updates on that same edge.
    assign w_mode_sel = ((r_state == S_IDLE) || (r_state == S_DONE)) ? mode : r_mode;
    assign w_prev     = w_pkt_start ? '0 : r_word;
    assign w_m_use    = w_pkt_start ? 6'd1 : r_m;
    assign w_ph_use   = w_pkt_start ? 1'b0 : r_ph;
    assign w_m_nxt    = (w_m_use == c_W6) ? 6'd1 : (w_m_use + 6'd1);
    assign w_ph_nxt   = (w_m_use == c_W6) ? ~w_ph_use : w_ph_use;

    assign w_x1    = r_x  ^ (r_x  << 13);
    assign w_x2    = w_x1 ^ (w_x1 >> 17);
    assign w_x_nxt = w_x2 ^ (w_x2 << 5);

    always_comb begin
        w_word_nxt = '0;
        case (w_mode_sel)
            2'd0: begin
                // Thermometer: high-ones mask on (m odd) XOR ph, else m low ones.
                if (w_m_use[0] ^ w_ph_use) begin
                    w_word_nxt = c_ONES << w_m_use;
                end else begin
                    w_word_nxt = c_ONES >> (c_W6 - w_m_use);
                end
            end
            2'd1:    w_word_nxt = w_x_nxt[W-1:0];
            2'd2:    w_word_nxt = w_prev + W'(1);
            default: w_word_nxt = ~w_prev;
        endcase
    end

    assign w_flit_idx_nxt = w_pkt_start ? '0 : (r_flit_idx + FW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_word      <= '0;
            r_x         <= SEED;
            r_m         <= 6'd1;
            r_ph        <= 1'b0;
            r_flit_idx  <= '0;
            r_pkt_idx   <= '0;
            r_gap_cnt   <= '0;
            r_pkt_count <= 16'd0;
            r_valid     <= 1'b0;
            r_flit_last <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_SEND);
            r_busy  <= (w_state_nxt == S_SEND) || (w_state_nxt == S_GAP);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_start_ok) begin
                r_mode      <= mode;
                r_pkt_count <= 16'd0;
            end else if (w_accept && w_last_flit && (r_pkt_count != 16'hFFFF)) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end

            if (w_load) begin
                r_word      <= w_word_nxt;
                r_m         <= w_m_nxt;
                r_ph        <= w_ph_nxt;
                r_flit_idx  <= w_flit_idx_nxt;
                r_flit_last <= (w_flit_idx_nxt == FW'(PAYLOAD - 1));
                if (w_mode_sel == 2'd1) begin
                    r_x <= w_x_nxt;
                end
                if (w_pkt_start) begin
                    r_pkt_idx <= w_start_ok ? '0 : (r_pkt_idx + PW'(1));
                end
            end else if (w_state_nxt != S_SEND) begin
                r_flit_last <= 1'b0;
            end

            if ((r_state == S_SEND) && (w_state_nxt == S_GAP)) begin
                r_gap_cnt <= GW'(GAP - 1);
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign operand_a = r_word[N-1:0];
    assign operand_b = r_word[W-1:N];
    assign flit_last = r_flit_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire
